// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES batch capture controller.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [1:0] PT_CTR   = 2'd0;
  localparam logic [1:0] PT_SCAN  = 2'd1;
  localparam logic [1:0] PT_CHAIN = 2'd2;

  // Mode 3 has no meaning of its own and behaves as scan mode.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? PT_SCAN : mode;
  endfunction

endpackage

// File: rtl/aes_out_fifo.sv
// Synchronous first-word-fall-through FIFO for captured result words.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module aes_out_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the entry, so a full FIFO may still accept.
  assign do_push = push && (!full || do_pop);

  // Head word is forced to zero when empty so stale storage never shows.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write.
  // NOTE: the data array is deliberately not reset; validity is tracked by the
  // pointers alone, which keeps the storage as plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/aes_batch_ctrl.sv
// Batch controller: issues num_blocks encryptions to an external AES core,
// selects the plaintext per block, frames the capture trigger around each
// core operation and queues results in an output FIFO.
module aes_batch_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int               DATA_W     = 128,
  parameter int               KEY_W      = 256,
  parameter int               CNT_W      = 16,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [KEY_W-1:0] HW_KEY     = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] sc_pt,
  input  logic [KEY_W-1:0]  sc_key,
  input  logic [1:0]        pt_mode,
  input  logic              key_sel,
  input  logic              ct_out_sel,
  input  logic [CNT_W-1:0]  num_blocks,
  output logic              core_start,
  output logic [DATA_W-1:0] core_pt,
  output logic [KEY_W-1:0]  core_key,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_ct,
  output logic              trigger,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  blk_count
);

  state_t            state;
  logic [1:0]        mode_q;
  logic              ct_sel_q;
  logic [DATA_W-1:0] scan_pt_q;
  logic [CNT_W-1:0]  num_q;
  logic [DATA_W-1:0] ctr_reg;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic [DATA_W-1:0] fifo_wdata;
  logic              last_blk;

  // Control outputs decode the registered state; only one block is ever in
  // flight, so a free FIFO entry at issue is still free when the result lands.
  assign core_start = (state == ISSUE) && !fifo_full;
  assign trigger    = core_start || (state == WAIT);
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);
  assign out_valid  = !fifo_empty;

  // core_pt still holds this block's plaintext while waiting for the result.
  assign fifo_push  = (state == WAIT) && core_done;
  assign fifo_wdata = ct_sel_q ? core_ct : core_pt;
  assign last_blk   = ((blk_count + CNT_W'(1)) == num_q);

  aes_out_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (out_ready),
    .rdata (out_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Batch sequencer: config latch, plaintext selection, counters and state.
  // NOTE: every register here uses non-blocking assignment so that all
  // right-hand sides see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= PT_CTR;
      ct_sel_q  <= 1'b0;
      scan_pt_q <= '0;
      num_q     <= '0;
      ctr_reg   <= '0;
      core_pt   <= '0;
      core_key  <= '0;
      blk_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= norm_mode(pt_mode);
            ct_sel_q  <= ct_out_sel;
            scan_pt_q <= sc_pt;
            num_q     <= num_blocks;
            core_key  <= key_sel ? sc_key : HW_KEY;
            blk_count <= '0;
            // Counter and scan/chained modes differ only in the first source.
            core_pt   <= (norm_mode(pt_mode) == PT_CTR) ? ctr_reg : sc_pt;
            state     <= (num_blocks == '0) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          if (!fifo_full) begin
            if (mode_q == PT_CTR) ctr_reg <= ctr_reg + DATA_W'(1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (core_done) begin
            blk_count <= blk_count + CNT_W'(1);
            unique case (mode_q)
              PT_CTR:   core_pt <= ctr_reg;
              PT_CHAIN: core_pt <= core_ct;
              default:  core_pt <= scan_pt_q;
            endcase
            state <= last_blk ? FINISH : ISSUE;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_batch_ctrl.sv
// Scoreboard bench for aes_batch_ctrl with a behavioural AES core stub
// (ciphertext = plaintext + 1, result two cycles after the request).
module tb_aes_batch_ctrl;

  localparam int DW = 128;
  localparam int KW = 256;
  localparam int CW = 16;
  localparam int FD = 4;
  localparam logic [KW-1:0] HWK = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                   64'hA5A5_5A5A_0F0F_F0F0, 64'h1111_2222_3333_4444};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] sc_pt;
  logic [KW-1:0] sc_key;
  logic [1:0]    pt_mode;
  logic          key_sel;
  logic          ct_out_sel;
  logic [CW-1:0] num_blocks;
  logic          core_start;
  logic [DW-1:0] core_pt;
  logic [KW-1:0] core_key;
  logic          core_done;
  logic [DW-1:0] core_ct;
  logic          trigger;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] blk_count;

  aes_batch_ctrl #(
    .DATA_W(DW), .KEY_W(KW), .CNT_W(CW), .FIFO_DEPTH(FD), .HW_KEY(HWK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sc_pt(sc_pt), .sc_key(sc_key),
    .pt_mode(pt_mode), .key_sel(key_sel), .ct_out_sel(ct_out_sel),
    .num_blocks(num_blocks), .core_start(core_start), .core_pt(core_pt),
    .core_key(core_key), .core_done(core_done), .core_ct(core_ct),
    .trigger(trigger), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state.
  logic [DW-1:0] exp_out[$];
  logic [DW-1:0] exp_pt[$];
  logic [KW-1:0] exp_key;
  logic [DW-1:0] model_ctr = '0;

  // Observation state shared with the stimulus.
  int cyc = 0;
  int n_starts = 0;
  int n_done = 0;
  int done_cyc = -10;
  int last_core_done_cyc = -10;
  bit ready_rand = 1'b0;
  bit ready_val = 1'b1;

  task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer-side ready driver.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // AES core stub.
  initial begin
    logic [DW-1:0] held;
    int pend;
    pend = 0;
    held = '0;
    core_done = 1'b0;
    core_ct = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            core_done = 1'b1;
            core_ct = held + DW'(1);
          end
        end
        if (core_start) begin
          held = core_pt;
          pend = 2;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each FIFO transfer and on each core request.
  initial begin
    bit win;
    win = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        win = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got %0h expected no word", out_data);
          end else begin
            check("out_data", out_data, exp_out.pop_front());
          end
        end
        if (core_start) begin
          n_starts++;
          if (exp_pt.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL core_start_unexpected: got pt %0h expected no request", core_pt);
          end else begin
            check("core_pt", core_pt, exp_pt.pop_front());
          end
          check("core_key", core_key, exp_key);
        end
        // Capture window: from the request through the result cycle inclusive.
        check("trigger", trigger, core_start || win);
        if (core_start) win = 1'b1;
        if (core_done) begin
          win = 1'b0;
          last_core_done_cyc = cyc;
        end
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_batch(input int n, input int done0);
    for (int c = 0; c < 2000 && n_done == done0; c++) begin
      @(negedge clk);
      #1;
    end
    check("done_count", n_done, done0 + 1);
    check("blk_count", blk_count, n);
    if (n > 0) check("done_after_core_done", done_cyc, last_core_done_cyc + 1);
    @(negedge clk);
    #1;
    check("busy_after_done", busy, 1'b0);
    check("done_one_cycle", done, 1'b0);
  endtask

  task automatic run_batch(input logic [1:0] mode, input logic [DW-1:0] pt, input bit ksel,
                           input logic [KW-1:0] key, input bit ctsel, input int n,
                           input bit wait_end = 1'b1);
    logic [1:0]    m;
    logic [DW-1:0] p;
    logic [DW-1:0] prev_ct;
    int            done0;
    m = (mode == 2'd3) ? 2'd1 : mode;
    prev_ct = '0;
    for (int i = 0; i < n; i++) begin
      if (m == 2'd0)      p = model_ctr + DW'(i);
      else if (m == 2'd2) p = (i == 0) ? pt : prev_ct;
      else                p = pt;
      prev_ct = p + DW'(1);
      exp_pt.push_back(p);
      exp_out.push_back(ctsel ? p + DW'(1) : p);
    end
    if (m == 2'd0) model_ctr = model_ctr + DW'(n);
    exp_key = ksel ? key : HWK;

    @(posedge clk);
    #1;
    done0 = n_done;
    start = 1'b1;
    pt_mode = mode;
    sc_pt = pt;
    key_sel = ksel;
    sc_key = key;
    ct_out_sel = ctsel;
    num_blocks = CW'(n);
    @(posedge clk);
    #1;
    // Scramble the config to show it was latched.
    start = 1'b0;
    pt_mode = 2'($urandom);
    sc_pt = {$urandom, $urandom, $urandom, $urandom};
    sc_key = {8{$urandom}};
    key_sel = 1'($urandom);
    ct_out_sel = 1'($urandom);
    num_blocks = CW'($urandom);
    @(negedge clk);
    if (n == 0) begin
      check("zero_done_t1", done, 1'b1);
      check("zero_no_start", core_start, 1'b0);
    end else begin
      check("first_issue_t1", core_start, 1'b1);
    end
    #1;
    if (wait_end) wait_batch(n, done0);
  endtask

  task automatic drain();
    ready_rand = 1'b0;
    ready_val = 1'b1;
    for (int c = 0; c < 200 && out_valid; c++) begin
      @(negedge clk);
      #1;
    end
    check("drain_empty", out_valid, 1'b0);
    check("drain_queue", exp_out.size(), 0);
  endtask

  initial begin
    int s0;
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    sc_pt = '0;
    sc_key = '0;
    pt_mode = 2'd0;
    key_sel = 1'b0;
    ct_out_sel = 1'b0;
    num_blocks = '0;
    exp_key = HWK;
    repeat (3) @(posedge clk);
    #2;
    check("rst_core_start", core_start, 1'b0);
    check("rst_trigger", trigger, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_blk_count", blk_count, 0);
    check("rst_core_pt", core_pt, 0);
    check("rst_core_key", core_key, 0);
    rst_n = 1'b1;

    // Counter mode, plaintext output, hardcoded key; counter persists.
    run_batch(2'd0, '0, 1'b0, '0, 1'b0, 3);
    run_batch(2'd0, '0, 1'b0, '0, 1'b0, 2);
    drain();

    // Chained mode with scan key 1, ciphertext output.
    run_batch(2'd2, DW'('h10), 1'b1, KW'(1), 1'b1, 3);
    drain();

    // FIFO backpressure: four issues fill the FIFO, then the batch stalls.
    ready_val = 1'b0;
    s0 = n_starts;
    d0 = n_done;
    run_batch(2'd1, DW'('hABC), 1'b0, '0, 1'b0, 6, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    check("full_starts", n_starts - s0, 4);
    check("full_trigger", trigger, 1'b0);
    check("full_busy", busy, 1'b1);
    check("full_core_start", core_start, 1'b0);
    check("full_no_done", n_done, d0);
    ready_val = 1'b1;
    wait_batch(6, d0);
    check("full_total_starts", n_starts - s0, 6);
    drain();

    // Empty batch.
    s0 = n_starts;
    run_batch(2'd0, '0, 1'b0, '0, 1'b0, 0);
    repeat (3) @(negedge clk);
    #1;
    check("zero_out_valid", out_valid, 1'b0);
    check("zero_starts", n_starts - s0, 0);

    // Randomised batches with random consumer backpressure.
    for (int b = 0; b < 8; b++) begin
      drain();
      ready_rand = 1'b1;
      run_batch(2'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom),
                {8{$urandom}}, 1'($urandom), int'($urandom_range(1, 6)));
    end
    drain();

    // Reset while waiting on the core.
    run_batch(2'd0, '0, 1'b0, '0, 1'b0, 3, 1'b0);
    for (int c = 0; c < 50 && !(trigger && !core_start); c++) @(negedge clk);
    check("reached_wait", trigger && !core_start, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_core_start", core_start, 1'b0);
    check("mid_rst_trigger", trigger, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_blk_count", blk_count, 0);
    check("mid_rst_core_pt", core_pt, 0);
    check("mid_rst_core_key", core_key, 0);
    check("mid_rst_out_data", out_data, 0);
    exp_out.delete();
    exp_pt.delete();
    model_ctr = '0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    run_batch(2'd0, '0, 1'b0, '0, 1'b0, 2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
